// File: rtl/latch_strobe_tx_if.sv
// Handshake and latch-bus bundle for latch_strobe_tx.
// master: word producer plus latch bank observer. slave: the transmitter.
interface latch_strobe_tx_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             ena;
    logic             busy;
    logic             sent;

    modport master (
        output in_valid, in_data,
        input  in_ready, out, ena, busy, sent
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out, ena, busy, sent
    );
endinterface

// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx: accepts words over valid/ready and presents them to a bank
// of transparent latches. Each word runs through SETUP, PULSE and HOLD windows.
// The gate strobe (ena) is high only during PULSE.
// All outputs come straight from flops. Each flop is loaded from the next-state
// decode, so output timing lines up with the state register.
// Optional build macro: LATCH_TX_SKID_EN adds a one-entry skid buffer. With it,
// a second word can be taken during a transfer and launched without passing
// through IDLE.
module latch_strobe_tx #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    latch_strobe_tx_if.slave    bus
);

    // A zero-width gate pulse would never open the latches, so reject it outright.
    generate
        if (PULSE_CYC < 1 || PULSE_CYC > 255) begin : g_bad_pulse
            $error("latch_strobe_tx: PULSE_CYC must be in 1..255");
        end
        if (SETUP_CYC < 0 || SETUP_CYC > 255) begin : g_bad_setup
            $error("latch_strobe_tx: SETUP_CYC must be in 0..255");
        end
        if (HOLD_CYC < 0 || HOLD_CYC > 255) begin : g_bad_hold
            $error("latch_strobe_tx: HOLD_CYC must be in 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ena_q, ena_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;

    logic             accept;
    logic             launch;
    logic             finish;
    logic             last;
    logic [WIDTH-1:0] launch_data;

`ifdef LATCH_TX_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
`endif

    assign accept = bus.in_valid && in_ready_q;
    assign last   = (cnt_q == 8'd1);

    // Next-state, counter reload and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        launch      = 1'b0;
        finish      = 1'b0;
        launch_data = bus.in_data;
`ifdef LATCH_TX_SKID_EN
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    launch = 1'b1;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PULSE: begin
                if (last) begin
                    if (HOLD_CYC == 0) begin
                        finish = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (last) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (finish) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
`ifdef LATCH_TX_SKID_EN
            // Chain straight into the next transfer when a word is waiting.
            // A buffered word has priority; an empty buffer lets a word
            // arriving on this edge bypass it.
            if (skid_full_q) begin
                launch      = 1'b1;
                launch_data = skid_data_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                launch = 1'b1;
            end
`endif
        end
`ifdef LATCH_TX_SKID_EN
        else if (accept && state_q != IDLE) begin
            skid_full_d = 1'b1;
            skid_data_d = bus.in_data;
        end
`endif

        // out only moves when a word is launched.
        if (launch) begin
            out_d = launch_data;
            if (SETUP_CYC != 0) begin
                state_d = SETUP;
                cnt_d   = SETUP_LD;
            end else begin
                state_d = PULSE;
                cnt_d   = PULSE_LD;
            end
        end

        ena_d  = (state_d == PULSE);
        busy_d = (state_d != IDLE);
        sent_d = ((state_d == HOLD) || (state_d == PULSE && HOLD_CYC == 0))
                 && (cnt_d == 8'd1);
`ifdef LATCH_TX_SKID_EN
        in_ready_d = (state_d == IDLE) || !skid_full_d;
`else
        in_ready_d = (state_d == IDLE);
`endif
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            out_q      <= '0;
            ena_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            ena_q      <= ena_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
        end
    end

`ifdef LATCH_TX_SKID_EN
    // Skid buffer storage; emptied by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end
`endif

    assign bus.out      = out_q;
    assign bus.ena      = ena_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.sent     = sent_q;

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Directed bench for latch_strobe_tx: default timing plus one fast-extreme instance.
module tb_latch_strobe_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    latch_strobe_tx_if #(.WIDTH(4)) bus_d ();
    latch_strobe_tx_if #(.WIDTH(4)) bus_x ();

    latch_strobe_tx #(.WIDTH(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d)
    );

    latch_strobe_tx #(.WIDTH(4), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_x)
    );

`ifdef LATCH_TX_SKID_EN
    localparam int EXP_ACC_GAP = 1;
    localparam int EXP_ENA_GAP = 4;
`else
    localparam int EXP_ACC_GAP = 5;
    localparam int EXP_ENA_GAP = 5;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt, e1, e2, r1, r2, rises, sent_cnt, cyc;
        logic acc_now, ena_prev, out_ok, accepted;

        bus_d.in_valid = 1'b0;
        bus_d.in_data  = 4'h0;
        bus_x.in_valid = 1'b0;
        bus_x.in_data  = 4'h0;

        // ---------------- reset and release ----------------
        repeat (3) tick();
        chk("rst_out",   32'(bus_d.out), 32'h0);
        chk("rst_ena",   32'(bus_d.ena), 32'h0);
        chk("rst_ready", 32'(bus_d.in_ready), 32'h0);
        chk("rst_busy",  32'(bus_d.busy), 32'h0);
        chk("rst_sent",  32'(bus_d.sent), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(bus_d.in_ready), 32'h0);
        tick();
        chk("rel_ready_after_edge", 32'(bus_d.in_ready), 32'h1);
        repeat (2) tick();
        chk("rel_ena_idle",  32'(bus_d.ena), 32'h0);
        chk("rel_busy_idle", 32'(bus_d.busy), 32'h0);

        // ---------------- single word A ----------------
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 4'hA;
        tick();                                      // edge T0
        bus_d.in_valid = 1'b0;
        bus_d.in_data  = 4'h0;
        chk("one_t0_out",  32'(bus_d.out), 32'hA);
        chk("one_t0_ena",  32'(bus_d.ena), 32'h0);
        chk("one_t0_busy", 32'(bus_d.busy), 32'h1);
`ifndef LATCH_TX_SKID_EN
        chk("one_t0_ready", 32'(bus_d.in_ready), 32'h0);
`endif
        tick();
        chk("one_t1_ena",  32'(bus_d.ena), 32'h1);
        tick();
        chk("one_t2_ena",  32'(bus_d.ena), 32'h1);
        chk("one_t2_sent", 32'(bus_d.sent), 32'h0);
        tick();
        chk("one_t3_ena",  32'(bus_d.ena), 32'h0);
        chk("one_t3_sent", 32'(bus_d.sent), 32'h1);
        chk("one_t3_out",  32'(bus_d.out), 32'hA);
        tick();
        chk("one_t4_ready", 32'(bus_d.in_ready), 32'h1);
        chk("one_t4_sent",  32'(bus_d.sent), 32'h0);
        chk("one_t4_busy",  32'(bus_d.busy), 32'h0);
        chk("one_t4_out",   32'(bus_d.out), 32'hA);

        // ---------------- back-to-back 3, C ----------------
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 4'h3;
        acc_cnt = 0; e1 = 0; e2 = 0; r1 = 0; r2 = 0; rises = 0;
        sent_cnt = 0; cyc = 0; ena_prev = 1'b0; out_ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            acc_now = bus_d.in_valid && bus_d.in_ready;
            tick();
            cyc++;
            if (acc_now) begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    e1 = cyc;
                    bus_d.in_data = 4'hC;
                end else begin
                    e2 = cyc;
                    bus_d.in_valid = 1'b0;
                end
            end
            if (bus_d.ena && !ena_prev) begin
                rises++;
                if (rises == 1) r1 = cyc;
                else if (rises == 2) r2 = cyc;
            end
            if (bus_d.ena && rises == 1 && bus_d.out != 4'h3) out_ok = 1'b0;
            if (bus_d.sent) sent_cnt++;
            ena_prev = bus_d.ena;
        end
        chk("b2b_accepts",   32'(acc_cnt), 32'd2);
        chk("b2b_acc_gap",   32'(e2 - e1), 32'(EXP_ACC_GAP));
        chk("b2b_ena_gap",   32'(r2 - r1), 32'(EXP_ENA_GAP));
        chk("b2b_out3_held", 32'(out_ok), 32'h1);
        chk("b2b_out_final", 32'(bus_d.out), 32'hC);
        chk("b2b_sent_cnt",  32'(sent_cnt), 32'd2);

`ifndef LATCH_TX_SKID_EN
        // ---------------- backpressure hygiene ----------------
        sent_cnt = 0;
        accepted = 1'b0;
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 4'h6;
        tick();
        if (bus_d.sent) sent_cnt++;
        chk("bp_first_out", 32'(bus_d.out), 32'h6);
        for (int k = 0; k < 10; k++) begin
            if (bus_d.in_ready) begin
                bus_d.in_data = 4'hE;
                tick();
                if (bus_d.sent) sent_cnt++;
                accepted = 1'b1;
                break;
            end
            bus_d.in_data = k[0] ? 4'hF : 4'h1;
            tick();
            if (bus_d.sent) sent_cnt++;
            if (!bus_d.in_ready) chk($sformatf("bp_hold_out_%0d", k), 32'(bus_d.out), 32'h6);
        end
        chk("bp_second_accept", 32'(accepted), 32'h1);
        chk("bp_second_out",    32'(bus_d.out), 32'hE);
        bus_d.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_d.sent) sent_cnt++;
        end
        chk("bp_sent_cnt", 32'(sent_cnt), 32'd2);
`endif

        // ---------------- reset mid-pulse ----------------
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 4'hB;
        tick();
        bus_d.in_valid = 1'b0;
        tick();
        chk("mid_ena_before", 32'(bus_d.ena), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ena_async",  32'(bus_d.ena), 32'h0);
        chk("mid_out_async",  32'(bus_d.out), 32'h0);
        chk("mid_busy_async", 32'(bus_d.busy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_ready_after", 32'(bus_d.in_ready), 32'h1);
        chk("mid_busy_after",  32'(bus_d.busy), 32'h0);
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 4'h9;
        tick();
        bus_d.in_valid = 1'b0;
        chk("mid9_out", 32'(bus_d.out), 32'h9);
        tick();
        chk("mid9_ena", 32'(bus_d.ena), 32'h1);
        tick();
        tick();
        chk("mid9_sent", 32'(bus_d.sent), 32'h1);
        tick();
        chk("mid9_ready", 32'(bus_d.in_ready), 32'h1);

        // ---------------- extremes: S=0 P=1 H=0 ----------------
        chk("ext_idle_ready", 32'(bus_x.in_ready), 32'h1);
        bus_x.in_valid = 1'b1;
        bus_x.in_data  = 4'h5;
        tick();
        chk("ext_acc_ena",  32'(bus_x.ena), 32'h1);
        chk("ext_acc_sent", 32'(bus_x.sent), 32'h1);
        chk("ext_acc_out",  32'(bus_x.out), 32'h5);
`ifndef LATCH_TX_SKID_EN
        tick();
        chk("ext_t1_ena",   32'(bus_x.ena), 32'h0);
        chk("ext_t1_sent",  32'(bus_x.sent), 32'h0);
        chk("ext_t1_ready", 32'(bus_x.in_ready), 32'h1);
        tick();
        chk("ext_t2_ena",   32'(bus_x.ena), 32'h1);
`endif
        bus_x.in_valid = 1'b0;
        tick();
        chk("ext_end_ena", 32'(bus_x.ena), 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/latch_strobe_tx.md
Name: latch_strobe_tx

Overview:
- Transmit side for a bank of level-sensitive capture latches, each with D, Q and a gate G.
- Accepts data words through a valid/ready handshake and drives them onto a parallel data bus.
- Generates the latch gate strobe with programmable setup, pulse-width and hold windows, counted in clock cycles, so downstream latches capture each word cleanly.
- Sits between a word-producing datapath and any transparent-latch register bank.

Parameters:
- WIDTH, 4: data bus width in bits.
- SETUP_CYC, 1: cycles data is stable before the gate rises. Range 0..255.
- PULSE_CYC, 2: cycles the gate is high. Range 1..255; 0 is illegal and must fail elaboration.
- HOLD_CYC, 1: cycles data is held after the gate falls. Range 0..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  WIDTH  word to transmit.
- in_ready  out  1  block can accept a word this cycle.
- out  out  WIDTH  data bus to the latch D inputs.
- ena  out  1  latch gate strobe to the latch G inputs; active high.
- busy  out  1  a transfer is in progress (state is not IDLE).
- sent  out  1  one-cycle pulse on the last HOLD cycle (or last PULSE cycle if HOLD_CYC=0).

Behaviour:
- Reset (rst_n low) values, asynchronous:
  - out=0, ena=0, in_ready=0, busy=0, sent=0.
  - state=IDLE; counters=0.
- Reset takes effect immediately, including mid-transfer: ena drops without waiting for a clock.
- First rising edge after rst_n goes high: in_ready goes to 1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- State machine (IDLE, SETUP, PULSE, HOLD):
  - IDLE: in_ready=1. On an edge with in_valid&in_ready, load out<=in_data, set in_ready=0, busy=1, and go to SETUP (or to PULSE if SETUP_CYC=0).
  - SETUP: ena=0 for exactly SETUP_CYC cycles, then go to PULSE.
  - PULSE: ena=1 for exactly PULSE_CYC cycles, then go to HOLD (or to IDLE if HOLD_CYC=0).
  - HOLD: ena=0 for exactly HOLD_CYC cycles, then go to IDLE.
- out changes only at acceptance. It is held through SETUP, PULSE and HOLD, and retains its last value in IDLE.
- in_data and in_valid are ignored while in_ready=0. The producer must hold in_valid and in_data until the accepting edge.
- Accept-to-accept minimum period is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles; with defaults, 5 cycles.
- sent asserts on the final cycle of the transfer. in_ready rises on the following edge.
- ena is glitch-free: it is driven straight from a flop.
- ena never rises in the same cycle that out changes, provided SETUP_CYC≥1. With SETUP_CYC=0, out and ena change on the same edge; this is documented and legal.
- One internal down-counter, 8 bits wide, is reloaded at each state entry.

Optional Feature:
- Macro: LATCH_TX_SKID_EN.
- When defined:
  - A one-entry skid buffer is added.
  - in_ready stays 1 during a transfer while the buffer is empty; one word may be accepted into it.
  - At the end of a transfer, if the buffer is full, the block goes directly to SETUP (or PULSE) with the buffered word, skipping IDLE. out updates on that edge.
  - Steady-state period becomes SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
  - Reset clears the buffer.
  - in_ready=0 only when the buffer is full during a transfer.
- When undefined: the block behaves exactly as in Behaviour; there is no buffer.

Test Plan:
- Reset release: rst_n low→high → all outputs are 0. in_ready=1 one edge later. ena stays 0 with no valid input.
- Single word, defaults, in_data=4'hA accepted at edge T0:
  - out=A from T0.
  - ena=0 for cycle T0+0, then 1 for cycles T0+1..T0+2, then 0 at T0+3.
  - sent=1 at T0+3; in_ready=1 at T0+4.
- Back-to-back, in_valid held with words 3,C:
  - Second acceptance occurs exactly 5 cycles after the first.
  - out=3 is stable through the whole first ena pulse.
  - With LATCH_TX_SKID_EN, the second acceptance is at T0+1 and the second ena rises 4 cycles after the first.
- Extremes, SETUP_CYC=0, PULSE_CYC=1, HOLD_CYC=0, word 4'h5:
  - ena rises on the accept edge and is high for exactly 1 cycle.
  - sent is coincident with ena; period is 2.
- Reset mid-pulse: assert rst_n low while ena=1 → ena and out go to 0 immediately (asynchronously). After release the block is in IDLE, and a new word 4'h9 transfers normally.
- Backpressure hygiene: toggle in_data while busy with in_valid=1 → out is unchanged until the next accept edge. Exactly one sent pulse per accepted word.
